// File: rtl/p_pkg.sv
// Shared definitions for the long-kernel arbiter: state encoding,
// default sizing constants and the tag-width helper.
package p_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    localparam int DEF_NREQ = 4;
    localparam int DEF_DW   = 8;
    localparam int DEF_TMO  = 255;

    // Width of a requester index; a single requester still needs one bit.
    function automatic int tag_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/p_rr_pick.sv
// Combinational round-robin picker: finds the first bit of req & ~mask at
// or after start, wrapping modulo NREQ.
module p_rr_pick
    import p_pkg::*;
#(
    parameter int NREQ = DEF_NREQ,
    parameter int TAGW = tag_w(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [NREQ-1:0] mask,
    input  logic [TAGW-1:0] start,
    output logic            found,
    output logic [TAGW-1:0] idx
);

    logic [NREQ-1:0] eligible;

    assign eligible = req & ~mask;

    // Walk the candidates in priority order starting at start; first hit wins.
    always_comb begin
        int cand;
        // NOTE: every output gets a default before the loop so no path
        // leaves it unassigned, which would otherwise infer a latch.
        found = 1'b0;
        idx   = '0;
        cand  = 0;
        for (int off = 0; off < NREQ; off++) begin
            cand = (int'(start) + off) % NREQ;
            if (!found && eligible[cand]) begin
                found = 1'b1;
                idx   = TAGW'(cand);
            end
        end
    end

endmodule

// File: rtl/p_lk_arbiter.sv
// Round-robin arbiter sharing one long-kernel unit between NREQ decode
// controllers, with a registered req/ack handshake toward the unit,
// back-to-back grants and a sticky stall timeout.
module p_lk_arbiter
    import p_pkg::*;
#(
    parameter int NREQ = DEF_NREQ,
    parameter int DW   = DEF_DW,
    parameter int TAGW = tag_w(NREQ),
    parameter int TMO  = DEF_TMO
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [NREQ-1:0]  t_req,
    output logic [NREQ-1:0]  t_ack,
    input  logic [NREQ*DW-1:0] t_data,
    output logic             i_req,
    input  logic             i_ack,
    output logic [DW-1:0]    i_data,
    output logic [TAGW-1:0]  i_tag,
    output logic             err_timeout,
    input  logic             clr_err
);

    localparam int CW = (TMO < 2) ? 1 : $clog2(TMO + 1);
    localparam logic [CW-1:0] TMO_C = CW'(TMO);

    state_t          state_q;
    logic [TAGW-1:0] tag_q;
    logic [DW-1:0]   data_q;
    logic [TAGW-1:0] ptr_q;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            err_q, err_d;

    logic [TAGW-1:0] tag_inc;
    logic [TAGW-1:0] pick_start;
    logic [NREQ-1:0] pick_mask;
    logic            pick_found;
    logic [TAGW-1:0] pick_idx;
    logic            busy;
    logic            hit;

    assign busy    = (state_q == BUSY);
    assign tag_inc = (int'(tag_q) >= NREQ - 1) ? '0 : tag_q + 1'b1;

    // From IDLE search from the pointer; on an ack search past the grantee.
    assign pick_start = busy ? tag_inc : ptr_q;
    assign pick_mask  = busy ? (NREQ'(1) << tag_q) : '0;

    p_rr_pick #(
        .NREQ (NREQ),
        .TAGW (TAGW)
    ) u_pick (
        .req   (t_req),
        .mask  (pick_mask),
        .start (pick_start),
        .found (pick_found),
        .idx   (pick_idx)
    );

    // Ack goes back to the owner from flop state and i_ack only.
    assign t_ack       = (busy && i_ack) ? (NREQ'(1) << tag_q) : '0;
    assign i_req       = busy;
    assign i_tag       = tag_q;
    assign i_data      = data_q;
    assign err_timeout = err_q;

    // Stall counter and sticky flag; the flag sets only on a rising event,
    // so a clear while stalled wins once and the flag re-arms next cycle.
    always_comb begin
        cnt_d = '0;
        if (busy && !i_ack) begin
            cnt_d = (cnt_q == TMO_C) ? cnt_q : cnt_q + 1'b1;
        end
        hit   = (TMO != 0) && busy && !i_ack && (cnt_d == TMO_C) && !err_q;
        err_d = hit ? 1'b1 : (clr_err ? 1'b0 : err_q);
    end

    // Grant FSM with registered handshake, tag, payload and pointer.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            tag_q   <= '0;
            data_q  <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep every flop sampling the
            // pre-edge values, independent of statement order.
            cnt_q <= cnt_d;
            err_q <= err_d;
            unique case (state_q)
                IDLE: begin
                    if (pick_found) begin
                        state_q <= BUSY;
                        tag_q   <= pick_idx;
                        data_q  <= t_data[int'(pick_idx) * DW +: DW];
                    end
                end
                BUSY: begin
                    if (i_ack) begin
                        ptr_q <= tag_inc;
                        if (pick_found) begin
                            tag_q  <= pick_idx;
                            data_q <= t_data[int'(pick_idx) * DW +: DW];
                        end else begin
                            state_q <= IDLE;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_p_lk_arbiter.sv
// Directed bench for p_lk_arbiter: a vector table for grant ordering plus
// hand-written sequences for back-pressure, timeout, bubble, protocol
// violation and asynchronous reset.
module tb_p_lk_arbiter;

    logic        clk;
    logic        reset_n;
    logic [3:0]  t_req;
    logic [3:0]  t_ack;
    logic [31:0] t_data;
    logic        i_req;
    logic        i_ack;
    logic [7:0]  i_data;
    logic [1:0]  i_tag;
    logic        err_timeout;
    logic        clr_err;

    int n_vec = 0;
    int n_bad = 0;

    typedef struct {
        logic [3:0] req;
        logic       ack;
        logic       clr;
        logic       e_req;
        logic [1:0] e_tag;
        logic [7:0] e_data;
        logic [3:0] e_tack;
        logic       e_err;
    } vec_t;

    vec_t vecs[$];

    p_lk_arbiter #(
        .NREQ (4),
        .DW   (8),
        .TAGW (2),
        .TMO  (4)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .t_req       (t_req),
        .t_ack       (t_ack),
        .t_data      (t_data),
        .i_req       (i_req),
        .i_ack       (i_ack),
        .i_data      (i_data),
        .i_tag       (i_tag),
        .err_timeout (err_timeout),
        .clr_err     (clr_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog expired");
    end

    function automatic vec_t mk(input logic [3:0] req, input logic ack, input logic clr,
                                input logic e_req, input logic [1:0] e_tag,
                                input logic [7:0] e_data, input logic [3:0] e_tack,
                                input logic e_err);
        vec_t v;
        v.req = req; v.ack = ack; v.clr = clr;
        v.e_req = e_req; v.e_tag = e_tag; v.e_data = e_data;
        v.e_tack = e_tack; v.e_err = e_err;
        return v;
    endfunction

    task automatic check(input string name, input logic e_req, input logic [1:0] e_tag,
                         input logic [7:0] e_data, input logic [3:0] e_tack, input logic e_err);
        bit bad;
        bad = 0;
        n_vec++;
        if (i_req !== e_req) begin
            bad = 1;
            $display("FAIL %s i_req: got %b want %b", name, i_req, e_req);
        end
        if (i_tag !== e_tag) begin
            bad = 1;
            $display("FAIL %s i_tag: got %0d want %0d", name, i_tag, e_tag);
        end
        if (i_data !== e_data) begin
            bad = 1;
            $display("FAIL %s i_data: got %h want %h", name, i_data, e_data);
        end
        if (t_ack !== e_tack) begin
            bad = 1;
            $display("FAIL %s t_ack: got %b want %b", name, t_ack, e_tack);
        end
        if (err_timeout !== e_err) begin
            bad = 1;
            $display("FAIL %s err_timeout: got %b want %b", name, err_timeout, e_err);
        end
        if (bad) n_bad++;
    endtask

    // Drive inputs just after the rising edge; outputs are sampled on the falling edge.
    task automatic drive(input logic [3:0] req, input logic ack, input logic clr);
        @(posedge clk);
        #1;
        t_req   = req;
        i_ack   = ack;
        clr_err = clr;
        @(negedge clk);
    endtask

    task automatic do_reset();
        t_req   = '0;
        i_ack   = 1'b0;
        clr_err = 1'b0;
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        t_data = {8'hA3, 8'h0B, 8'hA1, 8'hA0};
        do_reset();

        // Reset state, round robin from pointer 0, then a single requester.
        vecs.push_back(mk(4'b0000, 0, 0, 0, 2'd0, 8'h00, 4'b0000, 0));
        vecs.push_back(mk(4'b1111, 1, 0, 0, 2'd0, 8'h00, 4'b0000, 0));
        vecs.push_back(mk(4'b1111, 1, 0, 1, 2'd0, 8'hA0, 4'b0001, 0));
        vecs.push_back(mk(4'b1111, 1, 0, 1, 2'd1, 8'hA1, 4'b0010, 0));
        vecs.push_back(mk(4'b1111, 1, 0, 1, 2'd2, 8'h0B, 4'b0100, 0));
        vecs.push_back(mk(4'b1111, 1, 0, 1, 2'd3, 8'hA3, 4'b1000, 0));
        vecs.push_back(mk(4'b1111, 1, 0, 1, 2'd0, 8'hA0, 4'b0001, 0));
        vecs.push_back(mk(4'b0010, 1, 0, 1, 2'd1, 8'hA1, 4'b0010, 0));
        vecs.push_back(mk(4'b0000, 0, 0, 0, 2'd1, 8'hA1, 4'b0000, 0));
        vecs.push_back(mk(4'b0100, 1, 0, 0, 2'd1, 8'hA1, 4'b0000, 0));
        vecs.push_back(mk(4'b0100, 1, 0, 1, 2'd2, 8'h0B, 4'b0100, 0));
        vecs.push_back(mk(4'b0000, 1, 0, 0, 2'd2, 8'h0B, 4'b0000, 0));

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].req, vecs[i].ack, vecs[i].clr);
            check($sformatf("vec%0d", i), vecs[i].e_req, vecs[i].e_tag,
                  vecs[i].e_data, vecs[i].e_tack, vecs[i].e_err);
        end

        // Back-pressure on requesters 1 and 3; the stall also trips the timeout.
        do_reset();
        drive(4'b1010, 0, 0); check("bp_idle", 0, 2'd0, 8'h00, 4'b0000, 0);
        for (int i = 1; i <= 4; i++) begin
            drive(4'b1010, 0, 0);
            check($sformatf("bp_hold%0d", i), 1, 2'd1, 8'hA1, 4'b0000, 0);
        end
        drive(4'b1010, 0, 0); check("bp_hold5_err", 1, 2'd1, 8'hA1, 4'b0000, 1);
        drive(4'b1010, 1, 1); check("bp_ack1",      1, 2'd1, 8'hA1, 4'b0010, 1);
        drive(4'b1000, 1, 0); check("bp_grant3",    1, 2'd3, 8'hA3, 4'b1000, 0);
        drive(4'b0000, 0, 0); check("bp_done",      0, 2'd3, 8'hA3, 4'b0000, 0);

        // Timeout set, clear while stalled, re-set, then ack plus clear.
        drive(4'b0001, 0, 0); check("tmo_idle", 0, 2'd3, 8'hA3, 4'b0000, 0);
        for (int i = 1; i <= 4; i++) begin
            drive(4'b0001, 0, 0);
            check($sformatf("tmo_wait%0d", i), 1, 2'd0, 8'hA0, 4'b0000, 0);
        end
        drive(4'b0001, 0, 1); check("tmo_set",     1, 2'd0, 8'hA0, 4'b0000, 1);
        drive(4'b0001, 0, 0); check("tmo_cleared", 1, 2'd0, 8'hA0, 4'b0000, 0);
        drive(4'b0001, 1, 1); check("tmo_reset",   1, 2'd0, 8'hA0, 4'b0001, 1);

        // Sole requester 0 keeps requesting: one IDLE bubble between grants.
        drive(4'b0001, 1, 0); check("bub_gap",   0, 2'd0, 8'hA0, 4'b0000, 0);
        drive(4'b0001, 1, 0); check("bub_again", 1, 2'd0, 8'hA0, 4'b0001, 0);
        drive(4'b0000, 1, 0); check("bub_idle",  0, 2'd0, 8'hA0, 4'b0000, 0);

        // Requester 2 withdraws early: request to the unit is held, ack still pulses.
        drive(4'b0100, 0, 0); check("viol_idle", 0, 2'd0, 8'hA0, 4'b0000, 0);
        drive(4'b0000, 0, 0); check("viol_hold", 1, 2'd2, 8'h0B, 4'b0000, 0);
        drive(4'b0000, 1, 0); check("viol_ack",  1, 2'd2, 8'h0B, 4'b0100, 0);

        // Asynchronous reset in the middle of a stalled grant to requester 2.
        drive(4'b0100, 0, 0); check("rst_idle", 0, 2'd2, 8'h0B, 4'b0000, 0);
        for (int i = 1; i <= 4; i++) begin
            drive(4'b0100, 0, 0);
            check($sformatf("rst_wait%0d", i), 1, 2'd2, 8'h0B, 4'b0000, 0);
        end
        drive(4'b0100, 0, 0); check("rst_err", 1, 2'd2, 8'h0B, 4'b0000, 1);
        #1;
        i_ack = 1'b1;
        t_req = 4'b1101;
        #1;
        check("rst_pre_ack", 1, 2'd2, 8'h0B, 4'b0100, 1);
        #1;
        reset_n = 1'b0;
        #1;
        check("rst_async", 0, 2'd0, 8'h00, 4'b0000, 0);
        @(negedge clk);
        #1;
        reset_n = 1'b1;
        drive(4'b1101, 1, 0); check("rst_first0", 1, 2'd0, 8'hA0, 4'b0001, 0);
        drive(4'b1100, 1, 0); check("rst_next2",  1, 2'd2, 8'h0B, 4'b0100, 0);
        drive(4'b1000, 1, 0); check("rst_next3",  1, 2'd3, 8'hA3, 4'b1000, 0);
        drive(4'b0000, 0, 0); check("rst_done",   0, 2'd3, 8'hA3, 4'b0000, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/p_lk_arbiter.md
Name: p_lk_arbiter

Overview:
Round-robin arbiter sharing one long-kernel (lk) execution unit between NREQ piston decode controllers. Each controller raises an lk request with a k_ctrl payload. The arbiter grants one requester at a time, registers the grantee's payload and tag, and presents a single registered req/ack handshake to the lk unit. It returns the ack to the owning requester and supports back-to-back grants. It also flags a stalled lk unit with a sticky timeout.

Parameters:
NREQ, 4, number of requesting decode controllers (2..16)
DW, 8, payload width (k_ctrl / selou width)
TAGW, 2, requester tag width = clog2(NREQ)
TMO, 255, cycles of unacknowledged i_req before err_timeout sets; 0 disables

Ports:
clk  input  1  clock
reset_n  input  1  asynchronous active-low reset
t_req  input  NREQ  per-requester request; held high until matching t_ack
t_ack  output  NREQ  per-requester ack; one-hot or zero
t_data  input  NREQ*DW  per-requester payload; slice g = bits [g*DW +: DW]; stable while t_req[g] high
i_req  output  1  request to lk unit (registered)
i_ack  input  1  lk unit accepts; transfer when i_req & i_ack
i_data  output  DW  registered payload of grantee
i_tag  output  TAGW  registered index of grantee
err_timeout  output  1  sticky stall flag
clr_err  input  1  synchronous clear of err_timeout

Behaviour:
- Reset (async, reset_n=0): state=IDLE, i_req=0, i_data=0, i_tag=0, rr pointer=0, wait counter=0, err_timeout=0. t_ack=0 combinationally. An in-flight transfer is dropped; requesters reissue.
- States: IDLE, BUSY. i_req = (state==BUSY), driven from a flop.
- IDLE: if any t_req bit is set, pick the first set bit at or after the pointer (wrapping modulo NREQ), latch its tag and t_data slice, go to BUSY next cycle. Grant latency = 1 cycle from t_req rise to i_req.
- BUSY and not i_ack: hold i_req, i_tag and i_data unchanged. Requests arriving meanwhile are not granted.
- BUSY and i_ack (same cycle):
  - t_ack[i_tag] = 1 combinationally; no other t_ack bit.
  - Pointer <= i_tag+1 (mod NREQ).
  - Re-arbitrate in the same cycle over t_req with bit i_tag masked, starting at i_tag+1.
  - Winner found: stay BUSY, load the new tag and data (back-to-back, no bubble).
  - None found: go to IDLE. The previous grantee may win again from IDLE next cycle, so one bubble when it is the sole requester.
- Protocol violation, t_req[i_tag] drops while BUSY: i_req is not withdrawn. The transfer completes on i_ack and t_ack[i_tag] still pulses; the requester ignores it. No other effect.
- t_ack is gated by the i_ack flop state only, never by t_req, which keeps the path acyclic.
- Wait counter:
  - Resets to 0 on entering BUSY and on every i_ack.
  - Increments each BUSY cycle without i_ack and saturates at TMO.
  - Counter reaching TMO (TMO≠0): err_timeout<=1.
  - clr_err=1: err_timeout<=0; set takes priority if both occur in the same cycle.
  - err_timeout does not block arbitration.
- Fairness: each requester waits at most NREQ-1 grants.
- NREQ=1: the pointer is constant 0 and i_tag is 0.

Decomposition:
- Shared package p_pkg: state encoding (IDLE=0, BUSY=1), default NREQ/DW/TMO constants, tag-width helper function.
- One natural sub-module, p_rr_pick. It is combinational with inputs req[NREQ], mask[NREQ] and start[TAGW], and outputs found and idx[TAGW] (first set bit of req&~mask at or after start, wrapping). It is instantiated once and shared by the IDLE and ack-cycle paths.

Test Plan:
- Single requester: t_req=4'b0100, t_data[2]=8'h0B; i_ack tied 1 → i_req high 1 cycle after t_req, i_tag=2, i_data=8'h0B, t_ack=4'b0100 in the same cycle as i_ack.
- All four requesting, pointer=0, i_ack=1 every cycle → grant order 0,1,2,3,0 with no bubbles; t_ack one-hot each cycle.
- Back-pressure: req 1 and 3, i_ack low 5 cycles → i_req, i_tag=1 and i_data stable for 5 cycles; on i_ack, t_ack=4'b0010, next cycle i_tag=3.
- Sole requester 0 re-requesting → grant, ack, one IDLE bubble cycle, grant again.
- TMO=4, i_ack held low → err_timeout=1 after 4 BUSY cycles; clr_err with i_ack still low → cleared, then counter stays at TMO so it sets again next cycle; after i_ack and clr_err, it stays 0.
- Reset asserted mid-BUSY with i_tag=2 → i_req, t_ack and err_timeout drop to 0 immediately (async); after release the pointer is 0 and requester 0 is served first if requesting.
